// File: rtl/lfsr_predict.sv
// Local copy of the far-end LFSR: predicts the next received bit from the
// last WIDTH received bits and flags a mismatch. Received bits are always
// shifted in, so the register tracks the channel rather than its own guess.
module lfsr_predict #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] FEEDBACK = 16'b0000_0000_0010_1101
) (
    input  logic clk,
    input  logic rst,
    input  logic bit_valid,
    input  logic bit_in,
    output logic expected,
    output logic mismatch,
    output logic is_zero
);

    logic [WIDTH-1:0] lreg;

    assign expected = ^(lreg & FEEDBACK);
    assign mismatch = bit_in ^ expected;
    assign is_zero  = (lreg == '0);

    // shift the received bit into the MSB on every valid bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lreg <= '0;
        else if (bit_valid)
            lreg <= {bit_in, lreg[WIDTH-1:1]};
    end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS receive checker: self-synchronises to a fibonacci LFSR stream,
// acquires lock after LOCK_COUNT good bits, drops lock when too many errors
// land in one WINDOW, and keeps a saturating count of locked-state errors.
module lfsr_checker #(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] FEEDBACK    = 16'b0000_0000_0010_1101,
    parameter int               LOCK_COUNT  = 32,
    parameter int               WINDOW      = 64,
    parameter int               LOSS_THRESH = 8,
    parameter int               CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_valid,
    input  logic                 bit_in,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 bit_error,
    output logic [CNT_WIDTH-1:0] error_count
);

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam int               FILL_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(WIDTH - 1);

    state_t              state;
    logic [FILL_W-1:0]   fill_cnt;
    logic [7:0]          good_cnt;
    logic [15:0]         win_cnt;
    logic [15:0]         win_err;

    logic                mismatch;
    logic                is_zero;
    logic                pred_expected_unused;

    logic [8:0]          good_inc;
    logic [16:0]         win_inc;
    logic [16:0]         err_next;

    lfsr_predict #(
        .WIDTH    (WIDTH),
        .FEEDBACK (FEEDBACK)
    ) u_predict (
        .clk       (clk),
        .rst       (rst),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .expected  (pred_expected_unused),
        .mismatch  (mismatch),
        .is_zero   (is_zero)
    );

    assign good_inc = {1'b0, good_cnt} + 9'd1;
    assign win_inc  = {1'b0, win_cnt} + 17'd1;
    assign err_next = {1'b0, win_err} + {16'd0, mismatch};

    // fill / hunt / locked sequencing, window accounting and registered flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_FILL;
            fill_cnt  <= '0;
            good_cnt  <= '0;
            win_cnt   <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            bit_error <= 1'b0;
        end else begin
            bit_error <= 1'b0;
            if (bit_valid) begin
                case (state)
                    ST_FILL: begin
                        // register contents are meaningless until WIDTH bits arrive
                        if (fill_cnt == FILL_LAST) begin
                            state    <= ST_HUNT;
                            fill_cnt <= '0;
                            good_cnt <= '0;
                        end else begin
                            fill_cnt <= fill_cnt + FILL_W'(1);
                        end
                    end
                    ST_HUNT: begin
                        // an all-zero register predicts zeros forever; never count it as good
                        if (mismatch || is_zero) begin
                            good_cnt <= '0;
                        end else if (good_inc == 9'(LOCK_COUNT)) begin
                            state    <= ST_LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else begin
                            good_cnt <= good_inc[7:0];
                        end
                    end
                    ST_LOCKED: begin
                        bit_error <= mismatch;
                        // loss beats window rollover on the same bit
                        if (err_next >= 17'(LOSS_THRESH)) begin
                            state    <= ST_HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                            win_cnt  <= '0;
                            win_err  <= '0;
                        end else if (win_inc == 17'(WINDOW)) begin
                            win_cnt <= '0;
                            win_err <= '0;
                        end else begin
                            win_cnt <= win_inc[15:0];
                            win_err <= err_next[15:0];
                        end
                    end
                    default: state <= ST_FILL;
                endcase
            end
        end
    end

    // saturating count of bit_error pulses; clear drops a coincident pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            error_count <= '0;
        else if (clear_count)
            error_count <= '0;
        else if (bit_error && (error_count != {CNT_WIDTH{1'b1}}))
            error_count <= error_count + CNT_WIDTH'(1);
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: hand sequences for lock/loss/clear/reset corners,
// a table of bit-flip scenarios, and a random stream against a history-based
// reference model. A second instance with a 3-bit counter covers saturation.
module tb_lfsr_checker;

    localparam int          W      = 16;
    localparam logic [15:0] FB     = 16'b0000_0000_0010_1101;
    localparam int          LOCK_N = 32;
    localparam int          WIN    = 64;
    localparam int          THR    = 8;

    localparam int P_FILL = 0;
    localparam int P_HUNT = 1;
    localparam int P_LOCK = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bit_valid;
    logic        bit_in;
    logic        clear_count;
    logic        locked, bit_error;
    logic [31:0] error_count;
    logic        locked3, bit_error3;
    logic [2:0]  error_count3;

    always #5 clk = ~clk;

    lfsr_checker #(.WIDTH(W), .FEEDBACK(FB), .LOCK_COUNT(LOCK_N), .WINDOW(WIN),
                   .LOSS_THRESH(THR), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear_count(clear_count), .locked(locked), .bit_error(bit_error),
        .error_count(error_count));

    lfsr_checker #(.WIDTH(W), .FEEDBACK(FB), .LOCK_COUNT(LOCK_N), .WINDOW(WIN),
                   .LOSS_THRESH(THR), .CNT_WIDTH(3)) dut3 (
        .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
        .clear_count(clear_count), .locked(locked3), .bit_error(bit_error3),
        .error_count(error_count3));

    int n_tests = 0;
    int n_fail  = 0;

    // reference model: last WIDTH received bits plus the rule counters
    bit     hist[$];
    int     m_phase, m_fill, m_good, m_wc, m_we;
    bit     m_locked, m_err;
    longint m_cnt;

    logic [15:0] gen;

    typedef struct {
        int fa;
        int fb;
        int exp_n;
        int exp_drop;
        int exp_relock;
    } vec_t;

    vec_t vecs[6];
    int   offs[5];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic gen_next(output bit b);
        b   = ^(gen & FB);
        gen = {b, gen[15:1]};
    endtask

    task automatic model_reset();
        hist.delete();
        m_phase = P_FILL; m_fill = 0; m_good = 0; m_wc = 0; m_we = 0;
        m_locked = 0; m_err = 0; m_cnt = 0;
    endtask

    task automatic model_edge(input bit v, input bit b, input bit c);
        bit exp_b, zero, mis;
        if (c) m_cnt = 0;
        else if (m_err) m_cnt++;
        m_err = 0;
        if (v) begin
            if (m_phase == P_FILL) begin
                m_fill++;
                if (m_fill == W) begin m_phase = P_HUNT; m_good = 0; end
            end else begin
                exp_b = 0; zero = 1;
                for (int i = 0; i < W; i++) begin
                    if (hist[i]) zero = 0;
                    if (FB[i]) exp_b ^= hist[i];
                end
                mis = (b != exp_b);
                if (m_phase == P_HUNT) begin
                    if (mis || zero) m_good = 0;
                    else begin
                        m_good++;
                        if (m_good == LOCK_N) begin
                            m_phase = P_LOCK; m_locked = 1; m_good = 0; m_wc = 0; m_we = 0;
                        end
                    end
                end else begin
                    m_err = mis;
                    if (m_we + int'(mis) >= THR) begin
                        m_phase = P_HUNT; m_locked = 0; m_good = 0;
                    end else begin
                        m_wc++; m_we += int'(mis);
                        if (m_wc == WIN) begin m_wc = 0; m_we = 0; end
                    end
                end
            end
            hist.push_back(b);
            if (hist.size() > W) void'(hist.pop_front());
        end
    endtask

    task automatic check_all();
        chk("locked",       {63'd0, locked},       {63'd0, m_locked});
        chk("bit_error",    {63'd0, bit_error},    {63'd0, m_err});
        chk("error_count",  {32'd0, error_count},  m_cnt);
        chk("locked3",      {63'd0, locked3},      {63'd0, m_locked});
        chk("error_count3", {61'd0, error_count3}, (m_cnt > 7) ? 64'd7 : m_cnt);
    endtask

    task automatic step(input bit v, input bit b, input bit c);
        bit_valid = v; bit_in = b; clear_count = c;
        @(posedge clk);
        model_edge(v, b, c);
        #1;
        check_all();
    endtask

    // async reset asserted between edges; outputs must clear before any edge
    task automatic do_reset();
        bit_valid = 0; bit_in = 0; clear_count = 0;
        #1 rst = 1'b1;
        model_reset();
        #1;
        check_all();
        #2 rst = 1'b0;
    endtask

    task automatic run_to_lock(output int nbits);
        bit b;
        nbits = -1;
        for (int k = 1; k <= 200; k++) begin
            gen_next(b);
            step(1, b, 0);
            if (locked) begin nbits = k; break; end
        end
    endtask

    initial begin
        int  lock_at, npulse, vbits, drop, relock, cyc;
        bit  b, ever;
        int  pulses[$];

        rst = 1'b0; bit_valid = 0; bit_in = 0; clear_count = 0;
        offs[0] = 0; offs[1] = 11; offs[2] = 13; offs[3] = 14; offs[4] = 16;
        vecs[0] = '{10, -1,  5, -1, -1};
        vecs[1] = '{30, -1,  5, -1, -1};
        vecs[2] = '{60, -1,  5, -1, -1};
        vecs[3] = '{ 4, 20,  8, 36, 68};
        vecs[4] = '{ 0, 30,  8, 43, 78};
        vecs[5] = '{50, 62, 10, -1, -1};

        @(negedge clk);
        do_reset();

        // lock acquisition from reset: 16 fill + 32 good bits
        gen = 16'hACE1; lock_at = -1; npulse = 0;
        for (int k = 1; k <= 60; k++) begin
            gen_next(b);
            step(1, b, 0);
            if (locked && lock_at < 0) lock_at = k;
            if (bit_error) npulse++;
        end
        chk("acq_lock_bit", lock_at, 48);
        chk("acq_pulses", npulse, 0);
        chk("acq_count", {32'd0, error_count}, 0);

        // flip scenarios measured in bits after lock
        foreach (vecs[r]) begin
            do_reset();
            gen = 16'hACE1;
            run_to_lock(lock_at);
            chk("row_lock_bit", lock_at, 48);
            pulses.delete(); drop = -1; relock = -1;
            for (int k = 0; k < 140; k++) begin
                gen_next(b);
                if (k == vecs[r].fa || k == vecs[r].fb) b = ~b;
                step(1, b, 0);
                if (bit_error) pulses.push_back(k);
                if (!locked && drop < 0) drop = k;
                if (drop >= 0 && locked && relock < 0) relock = k;
            end
            chk("row_pulses", pulses.size(), vecs[r].exp_n);
            chk("row_count", {32'd0, error_count}, vecs[r].exp_n);
            chk("row_count_sat3", {61'd0, error_count3}, (vecs[r].exp_n > 7) ? 7 : vecs[r].exp_n);
            chk("row_drop", drop, vecs[r].exp_drop);
            chk("row_relock", relock, vecs[r].exp_relock);
            if (vecs[r].fb < 0)
                for (int j = 0; j < 5; j++)
                    chk("row_pulse_off", (j < pulses.size()) ? pulses[j] : -1, vecs[r].fa + offs[j]);
        end

        // degenerate all-zero stream never locks; real stream then does
        do_reset();
        ever = 0;
        for (int k = 0; k < 200; k++) begin
            step(1, 0, 0);
            if (locked) ever = 1;
        end
        chk("zero_never_locked", ever, 0);
        gen = 16'hACE1;
        for (int k = 0; k < 48; k++) begin
            gen_next(b);
            step(1, b, 0);
        end
        chk("zero_then_lock", locked, 1);

        // idle gaps do not move the lock point in valid bits
        do_reset();
        gen = 16'h1234; vbits = 0; lock_at = -1; cyc = 0;
        while (vbits < 52 && cyc < 1000) begin
            cyc++;
            if ($urandom_range(0, 2) != 0) begin
                gen_next(b); vbits++;
                step(1, b, 0);
            end else begin
                step(0, 1'($urandom_range(0, 1)), 0);
            end
            if (locked && lock_at < 0) lock_at = vbits;
        end
        chk("gap_lock_bit", lock_at, 48);

        // clear coincident with a bit_error pulse drops that error
        gen_next(b);
        step(1, ~b, 0);
        chk("clr_pulse", bit_error, 1);
        gen_next(b);
        step(1, b, 1);
        chk("clr_count_zero", {32'd0, error_count}, 0);
        vbits = 0;
        while (vbits < 20) begin
            if ($urandom_range(0, 1) != 0) begin
                gen_next(b); vbits++;
                step(1, b, 0);
            end else begin
                step(0, 0, 0);
            end
        end
        chk("clr_count_after", {32'd0, error_count}, 4);
        chk("clr_still_locked", locked, 1);

        // mid-stream reset clears everything, then a full reacquire
        do_reset();
        chk("rst_locked", locked, 0);
        chk("rst_count", {32'd0, error_count}, 0);
        run_to_lock(lock_at);
        chk("rst_relock_bit", lock_at, 48);

        // random stream: errors, gaps, clears and occasional resets
        do_reset();
        gen = 16'hBEEF;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 1999) == 0) begin
                do_reset();
            end else if ($urandom_range(0, 3) != 0) begin
                gen_next(b);
                if ($urandom_range(0, 59) == 0) b = ~b;
                step(1, b, ($urandom_range(0, 99) == 0));
            end else begin
                step(0, 1'($urandom_range(0, 1)), ($urandom_range(0, 99) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

endmodule
